// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment scan driver.
// Scans one digit per refresh slot, decodes hex nibbles to segments, and
// applies per-digit blanking, leading-zero suppression, decimal point and
// PWM brightness. Display data is double-buffered and committed only at
// frame boundaries so the visible frame never tears.
module seg7_scan_driver #(
    parameter int NUM_DIGITS       = 4,
    parameter int REFRESH_DIV      = 100000,
    parameter int BRIGHT_W         = 4,
    parameter int ANODE_ACTIVE_LOW = 1,
    parameter int SEG_ACTIVE_LOW   = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [4*NUM_DIGITS-1:0]   digits_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic [NUM_DIGITS-1:0]     blank_in,
    input  logic                      lzs_en,
    input  logic [BRIGHT_W-1:0]       brightness,
    input  logic                      load,
    output logic [NUM_DIGITS-1:0]     anodeON,
    output logic [6:0]                cathodeOFF,
    output logic                      dp_out,
    output logic                      frame_done
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int unsigned STEP = REFRESH_DIV >> BRIGHT_W;
    localparam logic [NUM_DIGITS-1:0] ONE_HOT0 = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

    // Scan counters
    logic [PW-1:0]             r_presc;
    logic [IW-1:0]             r_idx;

    // Pending (written by load) and active (displayed) buffers
    logic [4*NUM_DIGITS-1:0]   r_pend_dig;
    logic [NUM_DIGITS-1:0]     r_pend_dp;
    logic [NUM_DIGITS-1:0]     r_pend_blank;
    logic                      r_pend_lzs;
    logic                      r_pend_valid;
    logic [4*NUM_DIGITS-1:0]   r_act_dig;
    logic [NUM_DIGITS-1:0]     r_act_dp;
    logic [NUM_DIGITS-1:0]     r_act_blank;
    logic                      r_act_lzs;

    // Brightness captured at each slot boundary
    logic [BRIGHT_W-1:0]       r_bright;

    // Registered outputs, active-high internally
    logic [NUM_DIGITS-1:0]     r_anode;
    logic [6:0]                r_seg;
    logic                      r_dp;
    logic                      r_frame_done;

    logic                      w_slot_end;
    logic                      w_frame_end;
    logic [NUM_DIGITS-1:0]     w_supp;
    logic [3:0]                w_nib;
    logic                      w_dark;
    logic [31:0]               w_on_cycles;
    logic                      w_lit;
    logic [6:0]                w_seg;

    function automatic logic [6:0] f_decode(input logic [3:0] nib);
        case (nib)
            4'h0: f_decode = 7'h3F;
            4'h1: f_decode = 7'h06;
            4'h2: f_decode = 7'h5B;
            4'h3: f_decode = 7'h4F;
            4'h4: f_decode = 7'h66;
            4'h5: f_decode = 7'h6D;
            4'h6: f_decode = 7'h7D;
            4'h7: f_decode = 7'h07;
            4'h8: f_decode = 7'h7F;
            4'h9: f_decode = 7'h6F;
            4'hA: f_decode = 7'h77;
            4'hB: f_decode = 7'h7C;
            4'hC: f_decode = 7'h39;
            4'hD: f_decode = 7'h5E;
            4'hE: f_decode = 7'h79;
            default: f_decode = 7'h71;
        endcase
    endfunction

    assign w_slot_end  = (r_presc == PW'(REFRESH_DIV - 1));
    assign w_frame_end = w_slot_end && (r_idx == IW'(NUM_DIGITS - 1));

    // Leading-zero chain: walk from the top digit down while every digit so far is zero
    always_comb begin : lzs_chain
        logic v_run;
        w_supp = '0;
        v_run  = r_act_lzs;
        for (int unsigned k = 1; k < NUM_DIGITS; k++) begin
            v_run = v_run && (r_act_dig[4*(NUM_DIGITS-k) +: 4] == 4'h0);
            w_supp[NUM_DIGITS-k] = v_run;
        end
    end

    // Current digit: lit only inside the PWM window, never in a slot's first cycle
    always_comb begin
        w_nib       = r_act_dig[{r_idx, 2'b00} +: 4];
        w_dark      = r_act_blank[r_idx] | w_supp[r_idx];
        w_on_cycles = (32'(r_bright) + 32'd1) * STEP;
        w_lit       = !w_dark && (r_presc != '0) && (32'(r_presc) <= w_on_cycles);
        w_seg       = f_decode(w_nib);
    end

    // Prescaler and digit index
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else if (w_slot_end) begin
            r_presc <= '0;
            r_idx   <= (r_idx == IW'(NUM_DIGITS - 1)) ? '0 : r_idx + IW'(1);
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    // Brightness takes effect from the next slot start
    always_ff @(posedge clk) begin
        if (!rst_n || w_slot_end) begin
            r_bright <= brightness;
        end
    end

    // Double buffer: a load at frame end bypasses straight to the active copy
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pend_dig   <= '0;
            r_pend_dp    <= '0;
            r_pend_blank <= '1;
            r_pend_lzs   <= 1'b0;
            r_pend_valid <= 1'b0;
            r_act_dig    <= '0;
            r_act_dp     <= '0;
            r_act_blank  <= '1;
            r_act_lzs    <= 1'b0;
        end else if (w_frame_end) begin
            if (load) begin
                r_act_dig   <= digits_in;
                r_act_dp    <= dp_in;
                r_act_blank <= blank_in;
                r_act_lzs   <= lzs_en;
            end else if (r_pend_valid) begin
                r_act_dig   <= r_pend_dig;
                r_act_dp    <= r_pend_dp;
                r_act_blank <= r_pend_blank;
                r_act_lzs   <= r_pend_lzs;
            end
            r_pend_valid <= 1'b0;
        end else if (load) begin
            r_pend_dig   <= digits_in;
            r_pend_dp    <= dp_in;
            r_pend_blank <= blank_in;
            r_pend_lzs   <= lzs_en;
            r_pend_valid <= 1'b1;
        end
    end

    // Output registers; segments are gated by the anode so dark cycles drive nothing
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_anode      <= '0;
            r_seg        <= '0;
            r_dp         <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_anode      <= w_lit ? (ONE_HOT0 << r_idx) : '0;
            r_seg        <= w_lit ? w_seg : '0;
            r_dp         <= w_lit & r_act_dp[r_idx];
            r_frame_done <= w_frame_end;
        end
    end

    assign anodeON    = (ANODE_ACTIVE_LOW != 0) ? ~r_anode : r_anode;
    assign cathodeOFF = (SEG_ACTIVE_LOW != 0) ? ~r_seg : r_seg;
    assign dp_out     = (SEG_ACTIVE_LOW != 0) ? ~r_dp : r_dp;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Testbench for seg7_scan_driver: directed scenarios plus randomized loads,
// all checked against a cycle-count based reference model.
module tb_seg7_scan_driver;

    localparam int N   = 4;
    localparam int DIV = 16;
    localparam int BW  = 2;
    localparam int FRAME = N * DIV;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [15:0]   digits_in = '0;
    logic [3:0]    dp_in = '0;
    logic [3:0]    blank_in = '0;
    logic          lzs_en = 1'b0;
    logic [1:0]    brightness = 2'd3;
    logic          load = 1'b0;
    logic [3:0]    anodeON;
    logic [6:0]    cathodeOFF;
    logic          dp_out;
    logic          frame_done;

    seg7_scan_driver #(
        .NUM_DIGITS(N),
        .REFRESH_DIV(DIV),
        .BRIGHT_W(BW),
        .ANODE_ACTIVE_LOW(1),
        .SEG_ACTIVE_LOW(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .digits_in(digits_in),
        .dp_in(dp_in),
        .blank_in(blank_in),
        .lzs_en(lzs_en),
        .brightness(brightness),
        .load(load),
        .anodeON(anodeON),
        .cathodeOFF(cathodeOFF),
        .dp_out(dp_out),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: time since reset plus the two buffers
    int          m_t;
    logic [15:0] m_ad, m_pd;
    logic [3:0]  m_adp, m_pdp, m_ab, m_pb;
    logic        m_al, m_pl, m_pv;
    logic [1:0]  m_br;

    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_dp, exp_fd;
    logic [12:0] obs, expv;

    logic [6:0] SEG [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // One clock: predict the outputs after this edge from the model, advance model and DUT
    task automatic step();
        int p, idx, on;
        logic lit, sup;
        logic [3:0] nib;
        p   = m_t % DIV;
        idx = (m_t / DIV) % N;
        nib = 4'(m_ad >> (4 * idx));
        sup = m_al && (idx >= 1) && ((m_ad >> (4 * idx)) == 16'h0);
        on  = (int'(m_br) + 1) * (DIV >> BW);
        lit = !m_ab[idx] && !sup && (p >= 1) && (p <= on);
        if (!rst_n) begin
            exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_fd = 1'b0;
            m_t = 0; m_ad = '0; m_pd = '0; m_adp = '0; m_pdp = '0;
            m_ab = '1; m_pb = '1; m_al = 1'b0; m_pl = 1'b0; m_pv = 1'b0;
            m_br = brightness;
        end else begin
            exp_an  = lit ? ~(4'b0001 << idx) : 4'hF;
            exp_seg = lit ? ~SEG[nib] : 7'h7F;
            exp_dp  = !(lit && m_adp[idx]);
            exp_fd  = (p == DIV - 1) && (idx == N - 1);
            if (p == DIV - 1) m_br = brightness;
            if (exp_fd) begin
                if (load) begin
                    m_ad = digits_in; m_adp = dp_in; m_ab = blank_in; m_al = lzs_en;
                end else if (m_pv) begin
                    m_ad = m_pd; m_adp = m_pdp; m_ab = m_pb; m_al = m_pl;
                end
                m_pv = 1'b0;
            end else if (load) begin
                m_pd = digits_in; m_pdp = dp_in; m_pb = blank_in; m_pl = lzs_en; m_pv = 1'b1;
            end
            m_t++;
        end
        @(posedge clk);
        #1;
        obs  = {anodeON, cathodeOFF, dp_out, frame_done};
        expv = {exp_an, exp_seg, exp_dp, exp_fd};
    endtask

    task automatic set_data(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl,
                            input logic lz);
        digits_in = d; dp_in = dp; blank_in = bl; lzs_en = lz;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            n_chk++;
            if (obs !== 13'h1FFE) $display("FAIL reset: got %h want %h", obs, 13'h1FFE);
            else n_pass++;
        end
        rst_n = 1'b1;
    endtask

    task automatic test_idle();
        int pulses = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            step();
            if (frame_done === 1'b1) pulses++;
            n_chk++;
            if (obs !== expv || anodeON !== 4'hF) $display("FAIL idle: got %h want %h", obs, expv);
            else n_pass++;
        end
        n_chk++;
        if (pulses !== 2) $display("FAIL idle_pulses: got %0d want 2", pulses);
        else n_pass++;
    endtask

    task automatic test_load();
        int on0 = 0;
        brightness = 2'd3;
        for (int i = 0; i < 20; i++) step();
        set_data(16'h1A3F, 4'h0, 4'h0, 1'b0);
        load = 1'b1;
        step();
        load = 1'b0;
        while (m_t % FRAME != 0) begin
            step();
            n_chk++;
            if (obs !== expv || anodeON !== 4'hF) $display("FAIL load_hold: got %h want %h", obs, expv);
            else n_pass++;
        end
        for (int i = 0; i < FRAME; i++) begin
            step();
            if (anodeON === 4'b1110) begin
                on0++;
                n_chk++;
                if (cathodeOFF !== ~7'h71) $display("FAIL load_seg0: got %h want %h", cathodeOFF, ~7'h71);
                else n_pass++;
            end
            n_chk++;
            if (obs !== expv) $display("FAIL load_show: got %h want %h", obs, expv);
            else n_pass++;
        end
        n_chk++;
        if (on0 !== 15) $display("FAIL load_on_cycles: got %0d want 15", on0);
        else n_pass++;
    endtask

    task automatic test_lzs();
        logic [15:0] pats [2] = '{16'h0050, 16'h0000};
        int lit_want [2] = '{30, 15};
        for (int k = 0; k < 2; k++) begin
            int lit = 0;
            set_data(pats[k], 4'hF, 4'h0, 1'b1);
            load = 1'b1;
            step();
            load = 1'b0;
            while (m_t % FRAME != 0) step();
            for (int i = 0; i < FRAME; i++) begin
                step();
                if (anodeON !== 4'hF) lit++;
                n_chk++;
                if (obs !== expv) $display("FAIL lzs_%0d: got %h want %h", k, obs, expv);
                else n_pass++;
            end
            n_chk++;
            if (lit !== lit_want[k]) $display("FAIL lzs_lit_%0d: got %0d want %0d", k, lit, lit_want[k]);
            else n_pass++;
        end
    endtask

    task automatic test_brightness();
        logic [1:0] lv [2] = '{2'd0, 2'd2};
        int want [2] = '{16, 48};
        set_data(16'h8888, 4'h0, 4'h0, 1'b0);
        load = 1'b1;
        step();
        load = 1'b0;
        for (int k = 0; k < 2; k++) begin
            int lit = 0;
            brightness = lv[k];
            while (m_t % FRAME != 0) step();
            for (int i = 0; i < FRAME; i++) step();
            for (int i = 0; i < FRAME; i++) begin
                step();
                if (anodeON !== 4'hF) lit++;
                n_chk++;
                if (obs !== expv) $display("FAIL bright_%0d: got %h want %h", lv[k], obs, expv);
                else n_pass++;
            end
            n_chk++;
            if (lit !== want[k]) $display("FAIL bright_lit_%0d: got %0d want %0d", lv[k], lit, want[k]);
            else n_pass++;
        end
        brightness = 2'd3;
    endtask

    task automatic test_back_to_back();
        while (m_t % FRAME != 10) step();
        set_data(16'h1111, 4'h0, 4'h0, 1'b0);
        load = 1'b1; step(); load = 1'b0;
        for (int i = 0; i < 5; i++) step();
        set_data(16'h2222, 4'h0, 4'h0, 1'b0);
        load = 1'b1; step(); load = 1'b0;
        while (m_t % FRAME != 0) step();
        for (int i = 0; i < 6; i++) step();
        n_chk++;
        if (cathodeOFF !== ~7'h5B) $display("FAIL b2b_2222: got %h want %h", cathodeOFF, ~7'h5B);
        else n_pass++;
        while (m_t % FRAME != FRAME - 1) begin
            step();
            n_chk++;
            if (obs !== expv) $display("FAIL b2b_frame2: got %h want %h", obs, expv);
            else n_pass++;
        end
        set_data(16'h3333, 4'h0, 4'h0, 1'b0);
        load = 1'b1; step(); load = 1'b0;
        for (int i = 0; i < 6; i++) step();
        n_chk++;
        if (cathodeOFF !== ~7'h4F) $display("FAIL b2b_3333: got %h want %h", cathodeOFF, ~7'h4F);
        else n_pass++;
        for (int i = 0; i < FRAME; i++) begin
            step();
            n_chk++;
            if (obs !== expv) $display("FAIL b2b_frame3: got %h want %h", obs, expv);
            else n_pass++;
        end
    endtask

    task automatic test_mid_reset();
        int lit = 0;
        while (m_t % FRAME != 2 * DIV + 7) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        n_chk++;
        if (obs !== 13'h1FFE) $display("FAIL midreset: got %h want %h", obs, 13'h1FFE);
        else n_pass++;
        for (int i = 0; i < 2 * FRAME; i++) begin
            step();
            if (anodeON !== 4'hF) lit++;
            n_chk++;
            if (obs !== expv) $display("FAIL midreset_run: got %h want %h", obs, expv);
            else n_pass++;
        end
        n_chk++;
        if (lit !== 0) $display("FAIL midreset_dark: got %0d want 0", lit);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 8 * FRAME; i++) begin
            load = ($urandom_range(0, 19) == 0);
            if (load) set_data(16'($urandom), 4'($urandom), 4'($urandom_range(0, 3)),
                               1'($urandom));
            if ($urandom_range(0, 99) == 0) brightness = 2'($urandom);
            step();
            n_chk++;
            if (obs !== expv) $display("FAIL random: got %h want %h", obs, expv);
            else n_pass++;
        end
        load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_idle();
        test_load();
        test_lzs();
        test_brightness();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
